// File: rtl/instr_link_pkg.sv
// Shared definitions for both ends of the instruction-load link:
// state encoding, default geometry and a constant-foldable clog2.
package instr_link_pkg;

  localparam int IWIDTH_DEF = 32;
  localparam int DEPTH_DEF  = 36;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2,
    ST_ERR  = 2'd3
  } link_state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 1; i < value; i = i * 2) r++;
    return r;
  endfunction

endpackage

// File: rtl/instr_ram.sv
// Local instruction store: synchronous write, registered read (read-before-write
// on an address collision), out-of-range read addresses return zero.
module instr_ram #(
  parameter int IWIDTH = 32,
  parameter int DEPTH  = 36,
  parameter int AWIDTH = 6
) (
  input  logic              r_clk,
  input  logic              r_rst,
  input  logic              we,
  input  logic [AWIDTH-1:0] waddr,
  input  logic [IWIDTH-1:0] wdata,
  input  logic [AWIDTH-1:0] raddr,
  output logic [IWIDTH-1:0] rdata
);

  localparam int AW1 = AWIDTH + 1;
  localparam logic [AWIDTH:0] DEPTH_W = AW1'(DEPTH);

  logic [IWIDTH-1:0] mem [DEPTH];

  // Array is deliberately not reset so it maps onto plain RAM.
  always_ff @(posedge r_clk) begin
    if (we && ({1'b0, waddr} < DEPTH_W)) mem[waddr] <= wdata;
  end

  always_ff @(posedge r_clk or negedge r_rst) begin
    if (!r_rst) begin
      rdata <= '0;
    end else if ({1'b0, raddr} < DEPTH_W) begin
      rdata <= mem[raddr];
    end else begin
      rdata <= '0;
    end
  end

endmodule

// File: rtl/instr_receiver.sv
// Receiving end of the instruction-load link: requests a stream with syn, stores
// acked words into the local RAM until last, and serves fetch reads from that RAM.
// Handshake: a word transfers on any rising edge where the FSM is in LOAD and
// r_i_ack=1; r_i_last is meaningful only on that same edge, and r_o_syn is the
// request that keeps the sender streaming one word per cycle.
module instr_receiver
  import instr_link_pkg::*;
#(
  parameter int IWIDTH  = IWIDTH_DEF,
  parameter int DEPTH   = DEPTH_DEF,
  parameter int AWIDTH  = clog2(DEPTH),
  parameter int TIMEOUT = 16
) (
  input  logic              r_clk,
  input  logic              r_rst,
  input  logic              r_i_start,
  output logic              r_o_syn,
  input  logic [IWIDTH-1:0] r_i_instr,
  input  logic              r_i_ack,
  input  logic              r_i_last,
  input  logic [AWIDTH-1:0] r_i_raddr,
  output logic [IWIDTH-1:0] r_o_rdata,
  output logic              r_o_busy,
  output logic              r_o_done,
  output logic              r_o_err,
  output logic [AWIDTH:0]   r_o_count,
  output link_state_t       r_o_state
);

  localparam int CWIDTH = AWIDTH + 1;
  localparam int TWIDTH = clog2(TIMEOUT + 1);

  link_state_t       state_q, state_d;
  logic [AWIDTH-1:0] wptr_q, wptr_d;
  logic [CWIDTH-1:0] count_q, count_d;
  logic [TWIDTH-1:0] timer_q, timer_d;
  logic              syn_q, busy_q, done_q, err_q;
  logic              we;

  always_comb begin
    state_d = state_q;
    wptr_d  = wptr_q;
    count_d = count_q;
    timer_d = timer_q;
    we      = 1'b0;
    case (state_q)
      ST_LOAD: begin
        if (r_i_ack) begin
          we      = 1'b1;
          wptr_d  = wptr_q + AWIDTH'(1);
          count_d = count_q + CWIDTH'(1);
          timer_d = '0;
          if (r_i_last) begin
            state_d = ST_DONE;
          end else if (wptr_q == AWIDTH'(DEPTH - 1)) begin
            // Image longer than the RAM: keep the last word, flag overflow.
            state_d = ST_ERR;
          end
        end else if (timer_q == TWIDTH'(TIMEOUT - 1)) begin
          state_d = ST_ERR;
        end else begin
          timer_d = timer_q + TWIDTH'(1);
        end
      end
      default: begin
        // IDLE, DONE and ERR all restart the same way; acks are ignored here.
        if (r_i_start) begin
          state_d = ST_LOAD;
          wptr_d  = '0;
          count_d = '0;
          timer_d = '0;
        end
      end
    endcase
  end

  always_ff @(posedge r_clk or negedge r_rst) begin
    if (!r_rst) begin
      state_q <= ST_IDLE;
      wptr_q  <= '0;
      count_q <= '0;
      timer_q <= '0;
      syn_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      count_q <= count_d;
      timer_q <= timer_d;
      syn_q   <= (state_d == ST_LOAD);
      busy_q  <= (state_d == ST_LOAD);
      done_q  <= (state_d == ST_DONE);
      err_q   <= (state_d == ST_ERR);
    end
  end

  instr_ram #(
    .IWIDTH(IWIDTH),
    .DEPTH (DEPTH),
    .AWIDTH(AWIDTH)
  ) u_ram (
    .r_clk(r_clk),
    .r_rst(r_rst),
    .we   (we),
    .waddr(wptr_q),
    .wdata(r_i_instr),
    .raddr(r_i_raddr),
    .rdata(r_o_rdata)
  );

  assign r_o_syn   = syn_q;
  assign r_o_busy  = busy_q;
  assign r_o_done  = done_q;
  assign r_o_err   = err_q;
  assign r_o_count = count_q;
  assign r_o_state = state_q;

endmodule

// File: tb/tb_instr_receiver.sv
// Directed bench for instr_receiver with a cycle-accurate sender model and a
// read-port scoreboard.
module tb_instr_receiver;
  import instr_link_pkg::*;

  localparam int IW = 32;
  localparam int DP = 36;
  localparam int AW = 6;

  logic          r_clk = 1'b0;
  logic          r_rst = 1'b0;
  logic          r_i_start = 1'b0;
  logic          r_o_syn;
  logic [IW-1:0] r_i_instr = '0;
  logic          r_i_ack = 1'b0;
  logic          r_i_last = 1'b0;
  logic [AW-1:0] r_i_raddr = '0;
  logic [IW-1:0] r_o_rdata;
  logic          r_o_busy, r_o_done, r_o_err;
  logic [AW:0]   r_o_count;
  link_state_t   r_o_state;

  instr_receiver #(.IWIDTH(IW), .DEPTH(DP), .AWIDTH(AW), .TIMEOUT(16)) dut (
    .r_clk(r_clk), .r_rst(r_rst), .r_i_start(r_i_start), .r_o_syn(r_o_syn),
    .r_i_instr(r_i_instr), .r_i_ack(r_i_ack), .r_i_last(r_i_last),
    .r_i_raddr(r_i_raddr), .r_o_rdata(r_o_rdata), .r_o_busy(r_o_busy),
    .r_o_done(r_o_done), .r_o_err(r_o_err), .r_o_count(r_o_count),
    .r_o_state(r_o_state)
  );

  // clock / reset
  always #5 r_clk = ~r_clk;
  int cyc = 0;
  always @(posedge r_clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;
  logic [IW-1:0] exp_q[$];
  logic rd_req = 1'b0;
  logic rd_fire = 1'b0;

  // sender model configuration
  int  k = 0;
  bit  syn_seen = 0;
  int  hold_k = -1;
  int  hold_left = 0;
  int  hold_start_cyc = -1;
  bit  never_last = 0;
  int  last_cyc = -1;
  int  done_cyc = -1;
  int  err_cyc = -1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Sender: answers syn seen on an edge with a word on the following cycle.
  initial forever begin
    @(negedge r_clk);
    if (!r_rst) begin
      k = 0; syn_seen = 0; r_i_ack = 0; r_i_last = 0; r_i_instr = '0;
    end else begin
      r_i_ack = 0;
      r_i_last = 0;
      if (syn_seen) begin
        if (k == hold_k && hold_left > 0) begin
          if (hold_start_cyc < 0) hold_start_cyc = cyc;
          hold_left--;
        end else begin
          r_i_ack = 1;
          r_i_instr = 32'hA000_0000 + k;
          r_i_last = !never_last && (k == DP - 1);
          if (r_i_last) last_cyc = cyc;
          k = (k == DP - 1) ? 0 : k + 1;
        end
      end
      syn_seen = r_o_syn;
    end
  end

  // scoreboard monitor for the read port
  always @(posedge r_clk) rd_fire <= rd_req;
  always @(negedge r_clk) begin
    if (rd_fire) begin
      if (exp_q.size() == 0) begin
        check("rdata_unexpected", 32'h1, 32'h0);
      end else begin
        check("rdata", r_o_rdata, exp_q.pop_front());
      end
    end
  end

  // driver tasks
  task automatic rd(input logic [AW-1:0] addr, input logic [IW-1:0] exp);
    @(negedge r_clk);
    r_i_raddr = addr;
    rd_req = 1'b1;
    exp_q.push_back(exp);
    @(negedge r_clk);
    rd_req = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge r_clk);
    r_i_start = 1'b1;
    @(negedge r_clk);
    r_i_start = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge r_clk);
    r_rst = 1'b0;
    hold_k = -1; hold_left = 0; hold_start_cyc = -1; never_last = 0;
    repeat (2) @(negedge r_clk);
    r_rst = 1'b1;
  endtask

  task automatic wait_for(input int sel, input int max_cyc, input string name);
    bit hit;
    hit = 0;
    for (int i = 0; i < max_cyc && !hit; i++) begin
      @(negedge r_clk);
      case (sel)
        0: begin hit = r_o_done; if (hit) done_cyc = cyc; end
        1: begin hit = r_o_err;  if (hit) err_cyc = cyc; end
        2: hit = (r_o_count == 7'd10);
        default: hit = (hold_start_cyc >= 0);
      endcase
    end
    if (!hit) begin
      n_checks++;
      n_errors++;
      $display("FAIL timeout_%s: event not seen within %0d cycles", name, max_cyc);
    end
  endtask

  initial begin
    // 1: reset values
    #12;
    check("rst_syn", r_o_syn, 0);
    check("rst_busy", r_o_busy, 0);
    check("rst_done", r_o_done, 0);
    check("rst_err", r_o_err, 0);
    check("rst_count", r_o_count, 0);
    check("rst_rdata", r_o_rdata, 0);
    check("rst_state", r_o_state, ST_IDLE);
    @(negedge r_clk);
    r_rst = 1'b1;

    // 2 + 6: full load with a stray start mid-load, then reads
    pulse_start();
    repeat (10) @(negedge r_clk);
    r_i_start = 1'b1;
    @(negedge r_clk);
    r_i_start = 1'b0;
    wait_for(0, 100, "done_full");
    check("full_done", r_o_done, 1);
    check("full_count", r_o_count, 36);
    check("full_syn", r_o_syn, 0);
    check("full_done_latency", done_cyc - last_cyc, 1);
    repeat (3) @(negedge r_clk);
    check("trail_count", r_o_count, 36);
    check("trail_done", r_o_done, 1);
    rd(0, 32'hA000_0000);
    rd(5, 32'hA000_0005);
    rd(35, 32'hA000_0023);
    rd(40, 32'h0);

    // 3a: ack withheld 5 cycles mid-stream
    do_reset();
    hold_k = 8; hold_left = 5;
    pulse_start();
    wait_for(3, 60, "hold5");
    check("hold_count_a", r_o_count, 8);
    repeat (2) @(negedge r_clk);
    check("hold_count_b", r_o_count, 8);
    check("hold_busy", r_o_busy, 1);
    wait_for(0, 100, "done_hold");
    check("hold_done_count", r_o_count, 36);
    check("hold_no_err", r_o_err, 0);
    rd(8, 32'hA000_0008);

    // 3b: ack withheld 16 cycles -> timeout
    do_reset();
    hold_k = 4; hold_left = 20;
    pulse_start();
    wait_for(3, 60, "hold16");
    wait_for(1, 40, "err_timeout");
    check("to_err", r_o_err, 1);
    check("to_syn", r_o_syn, 0);
    check("to_busy", r_o_busy, 0);
    check("to_count", r_o_count, 4);
    check("to_latency", err_cyc - hold_start_cyc, 16);

    // 4: no last -> overflow after 36 words
    do_reset();
    never_last = 1;
    pulse_start();
    wait_for(1, 100, "err_overflow");
    check("ovf_err", r_o_err, 1);
    check("ovf_count", r_o_count, 36);
    check("ovf_done", r_o_done, 0);
    repeat (3) @(negedge r_clk);
    check("ovf_count_hold", r_o_count, 36);
    rd(35, 32'hA000_0023);

    // 5: async reset mid-load, then a clean reload
    do_reset();
    r_i_raddr = 5;
    pulse_start();
    wait_for(2, 60, "count10");
    #2 r_rst = 1'b0;
    #1;
    check("mid_syn", r_o_syn, 0);
    check("mid_busy", r_o_busy, 0);
    check("mid_count", r_o_count, 0);
    check("mid_done", r_o_done, 0);
    check("mid_err", r_o_err, 0);
    check("mid_rdata", r_o_rdata, 0);
    repeat (2) @(negedge r_clk);
    r_rst = 1'b1;
    pulse_start();
    wait_for(0, 100, "done_reload");
    check("reload_done", r_o_done, 1);
    check("reload_count", r_o_count, 36);
    rd(10, 32'hA000_000A);

    repeat (2) @(negedge r_clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
